// File: rtl/sram_mem_arbiter.sv
// sram_mem_arbiter
// Shares one single-port 16-bit SRAM between instruction fetch (read-only)
// and the memory stage (load/store). Each 32-bit access becomes two 16-bit
// half accesses, low half first, each lasting WAIT_CYCLES cycles, followed
// by a one-cycle ready pulse to the granted requester. MEM has fixed
// priority over IF.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request (level) and byte address
//   if_rdata/if_ready        fetched word and its one-cycle valid pulse
//   mem_rd_en/mem_wr_en      load / store request (level)
//   mem_addr/mem_wdata       data byte address and store data
//   mem_rdata/mem_ready      load data and load/store done pulse
//   sram_addr                half-word address to the SRAM
//   sram_dq_out/sram_dq_oe   write data and pad drive enable
//   sram_dq_in               read data from the pad
//   sram_we_n                write strobe, active-low
module sram_mem_arbiter #(
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_req,
   input  logic [31:0]            if_addr,
   output logic [31:0]            if_rdata,
   output logic                   if_ready,
   input  logic                   mem_rd_en,
   input  logic                   mem_wr_en,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_wdata,
   output logic [31:0]            mem_rdata,
   output logic                   mem_ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_we_n
);

   localparam int         WORD_W  = SRAM_ADDR_W - 1;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              owner_mem, owner_mem_nxt;
   logic              op_wr, op_wr_nxt;
   logic [WORD_W-1:0] word, word_nxt;
   logic [31:0]       wdata, wdata_nxt;
   logic [15:0]       lo_buf;

   logic [SRAM_ADDR_W-1:0] sram_addr_nxt;
   logic [15:0]            dq_out_nxt;
   logic                   drive_nxt;
   logic                   if_ready_nxt, mem_ready_nxt;
   logic                   phase_end, cap_lo, cap_hi;

   // Byte-offset bits and bits above the SRAM size are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[31:SRAM_ADDR_W+1], if_addr[1:0],
                               mem_addr[31:SRAM_ADDR_W+1], mem_addr[1:0]};

   assign phase_end = (cnt == 4'd1);
   assign cap_lo    = (state == LO) && phase_end && !op_wr;
   assign cap_hi    = (state == HI) && phase_end && !op_wr;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      owner_mem_nxt = owner_mem;
      op_wr_nxt     = op_wr;
      word_nxt      = word;
      wdata_nxt     = wdata;

      case (state)
         IDLE: begin
            if (mem_rd_en || mem_wr_en) begin
               owner_mem_nxt = 1'b1;
               op_wr_nxt     = mem_wr_en;  // rd+wr together counts as a write
               word_nxt      = mem_addr[SRAM_ADDR_W:2];
               wdata_nxt     = mem_wdata;
               state_nxt     = LO;
               cnt_nxt       = WAIT_LD;
            end else if (if_req) begin
               owner_mem_nxt = 1'b0;
               op_wr_nxt     = 1'b0;
               word_nxt      = if_addr[SRAM_ADDR_W:2];
               state_nxt     = LO;
               cnt_nxt       = WAIT_LD;
            end
         end
         LO: begin
            if (phase_end) begin
               state_nxt = HI;
               cnt_nxt   = WAIT_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         HI: begin
            if (phase_end) begin
               state_nxt = RESP;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            // RESP: requests are not sampled here
            state_nxt = IDLE;
         end
      endcase

      // SRAM pins are registered from the next state so they are valid for
      // the whole phase; the address holds its last value when idle.
      sram_addr_nxt = sram_addr;
      dq_out_nxt    = sram_dq_out;
      if (state_nxt == LO) begin
         sram_addr_nxt = {word_nxt, 1'b0};
         if (op_wr_nxt) dq_out_nxt = wdata_nxt[15:0];
      end else if (state_nxt == HI) begin
         sram_addr_nxt = {word_nxt, 1'b1};
         if (op_wr_nxt) dq_out_nxt = wdata_nxt[31:16];
      end
      drive_nxt     = op_wr_nxt && ((state_nxt == LO) || (state_nxt == HI));
      if_ready_nxt  = (state_nxt == RESP) && !owner_mem_nxt;
      mem_ready_nxt = (state_nxt == RESP) && owner_mem_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         owner_mem <= 1'b0;
         op_wr     <= 1'b0;
         word      <= '0;
         wdata     <= 32'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         owner_mem <= owner_mem_nxt;
         op_wr     <= op_wr_nxt;
         word      <= word_nxt;
         wdata     <= wdata_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sram_addr   <= '0;
         sram_dq_out <= 16'd0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         if_ready    <= 1'b0;
         mem_ready   <= 1'b0;
      end else begin
         sram_addr   <= sram_addr_nxt;
         sram_dq_out <= dq_out_nxt;
         sram_dq_oe  <= drive_nxt;
         sram_we_n   <= !drive_nxt;
         if_ready    <= if_ready_nxt;
         mem_ready   <= mem_ready_nxt;
      end
   end

   // The low half is staged in lo_buf so the visible rdata register changes
   // only once, when the high half arrives, and holds its previous word
   // throughout the access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lo_buf    <= 16'd0;
         if_rdata  <= 32'd0;
         mem_rdata <= 32'd0;
      end else begin
         if (cap_lo) lo_buf <= sram_dq_in;
         if (cap_hi) begin
            if (owner_mem) mem_rdata <= {sram_dq_in, lo_buf};
            else           if_rdata  <= {sram_dq_in, lo_buf};
         end
      end
   end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
module tb_sram_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_clr;

   // instance A: WAIT_CYCLES=1, 18-bit SRAM address
   logic        if_req, mem_rd_en, mem_wr_en;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] if_rdata, mem_rdata;
   logic        if_ready, mem_ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   // instance B: WAIT_CYCLES=3, 10-bit SRAM address
   logic        b_if_req, b_mem_rd_en, b_mem_wr_en;
   logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata;
   logic [31:0] b_if_rdata, b_mem_rdata;
   logic        b_if_ready, b_mem_ready;
   logic [9:0]  b_sram_addr;
   logic [15:0] b_sram_dq_out, b_sram_dq_in;
   logic        b_sram_dq_oe, b_sram_we_n;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_exp_q[$];
   logic [31:0] if_exp_q[$];
   logic [31:0] shadow[int];
   logic [31:0] last_mem_rd;

   logic [15:0] sram_a [0:262143];
   logic [15:0] sram_b [0:1023];

   always #5 clk = ~clk;

   sram_mem_arbiter #(.SRAM_ADDR_W(18), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   sram_mem_arbiter #(.SRAM_ADDR_W(10), .WAIT_CYCLES(3)) u_dut_b (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
      .mem_rd_en(b_mem_rd_en), .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
      .sram_addr(b_sram_addr), .sram_dq_out(b_sram_dq_out), .sram_dq_oe(b_sram_dq_oe),
      .sram_dq_in(b_sram_dq_in), .sram_we_n(b_sram_we_n)
   );

   function automatic logic [15:0] pat_a(input int i);
      return 16'(i) ^ 16'hA5C3;
   endfunction

   function automatic logic [15:0] pat_b(input int i);
      return 16'(i) ^ 16'h3C00;
   endfunction

   function automatic int widx(input logic [31:0] addr);
      return int'((addr >> 2) & 32'h0001_FFFF);
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] addr);
      int w;
      w = widx(addr);
      if (shadow.exists(w)) return shadow[w];
      return {pat_a(2 * w + 1), pat_a(2 * w)};
   endfunction

   // SRAM models: asynchronous read, write on the rising edge while we_n=0
   assign sram_dq_in   = sram_a[sram_addr];
   assign b_sram_dq_in = sram_b[b_sram_addr];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 262144; i++) sram_a[i] <= pat_a(i);
      end else if (!sram_we_n) begin
         sram_a[sram_addr] <= sram_dq_out;
      end
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) sram_b[i] <= pat_b(i);
      end else if (!b_sram_we_n) begin
         sram_b[b_sram_addr] <= b_sram_dq_out;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 = MEM load, 1 = MEM store, 2 = IF fetch (all on instance A)
   task automatic do_txn(input int kind, input logic [31:0] addr,
                         input logic [31:0] wd, input string nm);
      int          lat;
      int          n;
      bit          other;
      logic [31:0] exp;
      logic [31:0] got;
      lat = -1;
      n = 0;
      other = 1'b0;
      if (kind == 2) begin
         if_exp_q.push_back(exp_word(addr));
         if_addr = addr;
         if_req = 1'b1;
      end else if (kind == 1) begin
         mem_exp_q.push_back(last_mem_rd);
         shadow[widx(addr)] = wd;
         mem_addr = addr;
         mem_wdata = wd;
         mem_wr_en = 1'b1;
      end else begin
         last_mem_rd = exp_word(addr);
         mem_exp_q.push_back(last_mem_rd);
         mem_addr = addr;
         mem_rd_en = 1'b1;
      end
      while (lat < 0 && n < 20) begin
         tick();
         n++;
         if ((kind == 2) ? mem_ready : if_ready) other = 1'b1;
         if ((kind == 2) ? if_ready : mem_ready) lat = n;
      end
      if_req = 1'b0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, expected 3", nm, lat);
      end
      checks++;
      if (other) begin
         errors++;
         $display("FAIL %s other_ready: other requester saw ready, expected none", nm);
      end
      exp = (kind == 2) ? ((if_exp_q.size() > 0) ? if_exp_q.pop_front() : 32'd0)
                        : ((mem_exp_q.size() > 0) ? mem_exp_q.pop_front() : 32'd0);
      got = (kind == 2) ? if_rdata : mem_rdata;
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s rdata: got %h, expected %h", nm, got, exp);
      end
      tick();
      checks++;
      if ({if_ready, mem_ready} !== 2'b00) begin
         errors++;
         $display("FAIL %s pulse_width: ready still %b, expected 00", nm, {if_ready, mem_ready});
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mem_clr = 1'b1;
      if_req = 1'b0; if_addr = 32'd0;
      mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
      b_if_req = 1'b0; b_if_addr = 32'd0;
      b_mem_rd_en = 1'b0; b_mem_wr_en = 1'b0; b_mem_addr = 32'd0; b_mem_wdata = 32'd0;
      last_mem_rd = 32'd0;
      tick();
      mem_clr = 1'b0;
      tick();
      checks++;
      if ({if_ready, mem_ready, sram_dq_oe, sram_we_n} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_ctrl_a: got %b, expected 0001", {if_ready, mem_ready, sram_dq_oe, sram_we_n});
      end
      checks++;
      if ({sram_addr, sram_dq_out} !== 34'd0) begin
         errors++;
         $display("FAIL reset_sram_a: addr %h dq %h, expected 0 0", sram_addr, sram_dq_out);
      end
      checks++;
      if ({if_rdata, mem_rdata} !== 64'd0) begin
         errors++;
         $display("FAIL reset_rdata_a: if %h mem %h, expected 0 0", if_rdata, mem_rdata);
      end
      checks++;
      if ({b_if_ready, b_mem_ready, b_sram_dq_oe, b_sram_we_n, b_sram_addr, b_sram_dq_out,
           b_if_rdata, b_mem_rdata} !== {4'b0001, 90'd0}) begin
         errors++;
         $display("FAIL reset_b: ctrl %b addr %h, expected 0001 0",
                  {b_if_ready, b_mem_ready, b_sram_dq_oe, b_sram_we_n}, b_sram_addr);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_write();
      logic [31:0] exp;
      mem_exp_q.push_back(last_mem_rd);
      shadow[widx(32'd1024)] = 32'h1234_ABCD;
      mem_addr = 32'd1024;
      mem_wdata = 32'h1234_ABCD;
      mem_wr_en = 1'b1;
      tick();
      checks++;
      if ({sram_addr, sram_dq_out, sram_we_n, sram_dq_oe} !== {18'd512, 16'hABCD, 2'b01}) begin
         errors++;
         $display("FAIL write_lo: addr %0d dq %h we_n %b oe %b, expected 512 abcd 0 1",
                  sram_addr, sram_dq_out, sram_we_n, sram_dq_oe);
      end
      tick();
      checks++;
      if ({sram_addr, sram_dq_out, sram_we_n, sram_dq_oe} !== {18'd513, 16'h1234, 2'b01}) begin
         errors++;
         $display("FAIL write_hi: addr %0d dq %h we_n %b oe %b, expected 513 1234 0 1",
                  sram_addr, sram_dq_out, sram_we_n, sram_dq_oe);
      end
      tick();
      mem_wr_en = 1'b0;
      checks++;
      if ({mem_ready, if_ready, sram_we_n, sram_dq_oe} !== 4'b1010) begin
         errors++;
         $display("FAIL write_resp: mem_rdy %b if_rdy %b we_n %b oe %b, expected 1 0 1 0",
                  mem_ready, if_ready, sram_we_n, sram_dq_oe);
      end
      exp = (mem_exp_q.size() > 0) ? mem_exp_q.pop_front() : 32'd0;
      checks++;
      if (mem_rdata !== exp) begin
         errors++;
         $display("FAIL write_rdata_kept: got %h, expected %h", mem_rdata, exp);
      end
      tick();
      checks++;
      if (mem_ready !== 1'b0) begin
         errors++;
         $display("FAIL write_pulse: mem_ready %b, expected 0", mem_ready);
      end
   endtask

   task automatic test_read();
      do_txn(0, 32'd1024, 32'd0, "read_1024");
      do_txn(0, 32'hFFF8_0402, 32'd0, "read_wrap");
      do_txn(2, 32'h0000_0200, 32'd0, "if_read");
      checks++;
      if (mem_rdata !== last_mem_rd) begin
         errors++;
         $display("FAIL if_read_mem_kept: mem_rdata %h, expected %h", mem_rdata, last_mem_rd);
      end
   endtask

   task automatic test_rd_wr_both();
      mem_exp_q.push_back(last_mem_rd);
      shadow[widx(32'h0000_0100)] = 32'hCAFE_F00D;
      mem_addr = 32'h0000_0100;
      mem_wdata = 32'hCAFE_F00D;
      mem_rd_en = 1'b1;
      mem_wr_en = 1'b1;
      tick();
      checks++;
      if ({sram_we_n, sram_dq_oe} !== 2'b01) begin
         errors++;
         $display("FAIL both_is_write: we_n %b oe %b, expected 0 1", sram_we_n, sram_dq_oe);
      end
      tick();
      tick();
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      checks++;
      if ({mem_ready, mem_rdata} !== {1'b1, mem_exp_q.pop_front()}) begin
         errors++;
         $display("FAIL both_resp: ready %b rdata %h, expected 1 %h", mem_ready, mem_rdata, last_mem_rd);
      end
      tick();
      do_txn(0, 32'h0000_0100, 32'd0, "both_readback");
   endtask

   task automatic test_arbitration();
      int mem_lat;
      int if_lat;
      bit same;
      mem_lat = -1;
      if_lat = -1;
      same = 1'b0;
      last_mem_rd = exp_word(32'd1024);
      mem_exp_q.push_back(last_mem_rd);
      if_exp_q.push_back(exp_word(32'h0000_0040));
      if_addr = 32'h0000_0040;
      mem_addr = 32'd1024;
      if_req = 1'b1;
      mem_rd_en = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         tick();
         if (mem_ready && if_ready) same = 1'b1;
         if (mem_ready && mem_lat < 0) begin
            mem_lat = n;
            mem_rd_en = 1'b0;
            checks++;
            if (mem_rdata !== mem_exp_q.pop_front()) begin
               errors++;
               $display("FAIL arb_mem_rdata: got %h, expected %h", mem_rdata, last_mem_rd);
            end
         end
         if (if_ready && if_lat < 0) begin
            if_lat = n;
            if_req = 1'b0;
            checks++;
            if (if_rdata !== if_exp_q.pop_front()) begin
               errors++;
               $display("FAIL arb_if_rdata: got %h, expected %h", if_rdata, exp_word(32'h40));
            end
         end
      end
      if_req = 1'b0;
      mem_rd_en = 1'b0;
      checks++;
      if (mem_lat != 3 || if_lat != 7) begin
         errors++;
         $display("FAIL arb_order: mem at %0d if at %0d, expected 3 and 7", mem_lat, if_lat);
      end
      checks++;
      if (same) begin
         errors++;
         $display("FAIL arb_exclusive: both readies high together, expected never");
      end
      mem_exp_q.delete();
      if_exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int first;
      int second;
      first = -1;
      second = -1;
      mem_exp_q.push_back(exp_word(32'd1024));
      mem_addr = 32'd1024;
      mem_rd_en = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         tick();
         if (mem_ready) begin
            checks++;
            if (mem_rdata !== mem_exp_q.pop_front()) begin
               errors++;
               $display("FAIL b2b_rdata_%0d: got %h", n, mem_rdata);
            end
            if (first < 0) begin
               first = n;
               last_mem_rd = exp_word(32'h0000_0200);
               mem_exp_q.push_back(last_mem_rd);
               mem_addr = 32'h0000_0200;
            end else if (second < 0) begin
               second = n;
               mem_rd_en = 1'b0;
            end
         end
      end
      mem_rd_en = 1'b0;
      checks++;
      if (first != 3 || second != 7) begin
         errors++;
         $display("FAIL b2b_timing: ready at %0d and %0d, expected 3 and 7", first, second);
      end
      mem_exp_q.delete();
   endtask

   task automatic test_ignore_changes();
      last_mem_rd = exp_word(32'd1024);
      mem_exp_q.push_back(last_mem_rd);
      mem_addr = 32'd1024;
      mem_rd_en = 1'b1;
      tick();
      mem_addr = 32'h0000_0300;
      tick();
      tick();
      mem_rd_en = 1'b0;
      checks++;
      if ({mem_ready, mem_rdata} !== {1'b1, mem_exp_q.pop_front()}) begin
         errors++;
         $display("FAIL ignore_changes: ready %b rdata %h, expected 1 %h", mem_ready, mem_rdata, last_mem_rd);
      end
      tick();
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] old;
      bit          saw;
      old = exp_word(32'h0000_0800);
      saw = 1'b0;
      mem_addr = 32'h0000_0800;
      mem_wdata = 32'hDEAD_BEEF;
      mem_wr_en = 1'b1;
      tick();
      tick();
      checks++;
      if ({sram_we_n, sram_addr} !== {1'b0, 18'd1025}) begin
         errors++;
         $display("FAIL rstw_in_hi: we_n %b addr %0d, expected 0 1025", sram_we_n, sram_addr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({sram_we_n, sram_dq_oe, mem_ready} !== 3'b100) begin
         errors++;
         $display("FAIL rstw_release: we_n %b oe %b ready %b, expected 1 0 0", sram_we_n, sram_dq_oe, mem_ready);
      end
      mem_wr_en = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         if (mem_ready) saw = 1'b1;
      end
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         if (mem_ready) saw = 1'b1;
      end
      checks++;
      if (saw) begin
         errors++;
         $display("FAIL rstw_no_ready: mem_ready pulsed after abort, expected none");
      end
      // only the low half reached the SRAM before the abort
      shadow[widx(32'h0000_0800)] = {old[31:16], 16'hBEEF};
      last_mem_rd = 32'd0;
      do_txn(0, 32'h0000_0800, 32'd0, "rstw_readback");
   endtask

   task automatic test_wait3();
      int          lat;
      int          n;
      logic [31:0] exp;
      lat = -1;
      n = 0;
      if_exp_q.push_back({pat_b(5), pat_b(4)});
      b_if_addr = 32'd8;
      b_if_req = 1'b1;
      while (lat < 0 && n < 20) begin
         tick();
         n++;
         if (n <= 6) begin
            checks++;
            if (b_sram_addr !== ((n <= 3) ? 10'd4 : 10'd5)) begin
               errors++;
               $display("FAIL w3_addr_c%0d: got %0d, expected %0d", n, b_sram_addr, (n <= 3) ? 4 : 5);
            end
         end
         if (b_if_ready) lat = n;
      end
      b_if_req = 1'b0;
      checks++;
      if (lat != 7) begin
         errors++;
         $display("FAIL w3_latency: got %0d, expected 7", lat);
      end
      exp = (if_exp_q.size() > 0) ? if_exp_q.pop_front() : 32'd0;
      checks++;
      if (b_if_rdata !== exp) begin
         errors++;
         $display("FAIL w3_rdata: got %h, expected %h", b_if_rdata, exp);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_rd_wr_both();
      test_arbitration();
      test_back_to_back();
      test_ignore_changes();
      test_reset_mid_write();
      test_wait3();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
